sram_pkt_driver: RTL and testbench

//  Initiator side of the 56-bit SRAM test-chip packet interface. Accepts one

---
 rtl/sram_pkt_pkg.sv | 35 +++
 rtl/sram_pkt_encode.sv | 45 ++++
 rtl/sram_pkt_driver.sv | 157 +++++++++++++++
 tb/tb_sram_pkt_driver.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkt_pkg
//  Description : Shared definitions for the SRAM test-chip packet driver:
//                packet bit positions, the idle packet and the FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package sram_pkt_pkg;

  localparam int PKT_W      = 56;

  // Packet field positions
  localparam int SRAM_BIT   = 55;
  localparam int CSB0_BIT   = 54;
  localparam int WEB0_BIT   = 53;
  localparam int WMASK0_LSB = 49;
  localparam int ADDR0_LSB  = 41;
  localparam int DIN0_LSB   = 9;
  localparam int CSB1_BIT   = 8;
  localparam int ADDR1_LSB  = 0;

  // Both chip selects deasserted (active low), every other bit zero
  localparam logic [PKT_W-1:0] IDLE_PACKET = 56'h40_0000_0000_0100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_RESP  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_pkt_encode.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkt_encode
//  Description : Combinational command -> 56-bit packet encoder covering
//                writes, RW-port reads and RO-port reads.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_pkt_encode
  import sram_pkt_pkg::*;
(
  input  logic             write,
  input  logic             port,
  input  logic             sram,
  input  logic [7:0]       addr,
  input  logic [3:0]       wmask,
  input  logic [31:0]      wdata,
  output logic [PKT_W-1:0] packet
);

  // Build the packet from zero; the sram select is common to every command
  always_comb begin
    packet           = '0;
    packet[SRAM_BIT] = sram;
    if (write) begin
      // Writes always go through the RW port, regardless of port select
      packet[CSB0_BIT]              = 1'b0;
      packet[WEB0_BIT]              = 1'b0;
      packet[WMASK0_LSB +: 4]       = wmask;
      packet[ADDR0_LSB +: 8]        = addr;
      packet[DIN0_LSB +: 32]        = wdata;
      packet[CSB1_BIT]              = 1'b1;
    end else if (!port) begin
      packet[CSB0_BIT]              = 1'b0;
      packet[WEB0_BIT]              = 1'b1;
      packet[ADDR0_LSB +: 8]        = addr;
      packet[CSB1_BIT]              = 1'b1;
    end else begin
      packet[CSB0_BIT]              = 1'b1;
      packet[CSB1_BIT]              = 1'b0;
      packet[ADDR1_LSB +: 8]        = addr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_pkt_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkt_driver
//  Description : Initiator for the SRAM test-chip packet interface. Accepts a
//                single outstanding read/write command, drives the registered
//                packet with csb sequencing, samples read data after RD_LAT
//                cycles and returns a response with valid/ready handshake.
//                Define SRAM_PKT_DRV_STATS_EN to add wr_count/rd_count
//                saturating command counters.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_pkt_driver
  import sram_pkt_pkg::*;
#(
  parameter int RD_LAT   = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic             cmd_port,
  input  logic             cmd_sram,
  input  logic [7:0]       cmd_addr,
  input  logic [3:0]       cmd_wmask,
  input  logic [31:0]      cmd_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_write,
  output logic [31:0]      resp_data,
  output logic [PKT_W-1:0] packet_out,
  input  logic [31:0]      sram_data_in,
  output logic             busy
`ifdef SRAM_PKT_DRV_STATS_EN
  ,
  output logic [15:0]      wr_count,
  output logic [15:0]      rd_count
`endif
);

  // Down-counter reload values (counter reaches 0 on the last cycle)
  localparam logic [3:0] RD_LOAD  = 4'(RD_LAT - 1);
  localparam logic [3:0] GAP_LOAD = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

  state_t             state;
  state_t             next_state;
  logic [3:0]         cnt;
  logic               write_q;
  logic               cmd_hs;
  logic               resp_hs;
  logic [PKT_W-1:0]   enc_packet;

  assign cmd_hs  = cmd_valid & cmd_ready;
  assign resp_hs = (state == ST_RESP) & resp_ready;
  assign busy    = (state != ST_IDLE);

  // Encoder looks at the live command bus; it is only captured on handshake
  sram_pkt_encode u_encode (
    .write  (cmd_write),
    .port   (cmd_port),
    .sram   (cmd_sram),
    .addr   (cmd_addr),
    .wmask  (cmd_wmask),
    .wdata  (cmd_wdata),
    .packet (enc_packet)
  );

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (cmd_hs) next_state = ST_ISSUE;
      ST_ISSUE: next_state = write_q ? ST_ACK : ST_WAIT;
      ST_WAIT:  if (cnt == 4'd0) next_state = ST_RESP;
      ST_ACK:   next_state = ST_RESP;
      ST_RESP:  if (resp_ready) next_state = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:   if (cnt == 4'd0) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Shared down-counter: read latency in WAIT, idle gap in GAP
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt <= 4'd0;
    end else if (state == ST_ISSUE) begin
      cnt <= RD_LOAD;
    end else if (resp_hs) begin
      cnt <= GAP_LOAD;
    end else if ((state == ST_WAIT || state == ST_GAP) && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Handshake flags are registered so both are low through reset
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cmd_ready  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      cmd_ready  <= (next_state == ST_IDLE);
      resp_valid <= (next_state == ST_RESP);
    end
  end

  // Capture the command type and packet on handshake; hold through WAIT
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      write_q    <= 1'b0;
      packet_out <= IDLE_PACKET;
    end else if (cmd_hs) begin
      write_q    <= cmd_write;
      packet_out <= enc_packet;
    end else if (next_state != ST_WAIT) begin
      packet_out <= IDLE_PACKET;
    end
  end

  // Response payload: loaded on entry to RESP, held until accepted
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      resp_write <= 1'b0;
      resp_data  <= 32'd0;
    end else if (state == ST_WAIT && next_state == ST_RESP) begin
      resp_write <= 1'b0;
      resp_data  <= sram_data_in;
    end else if (state == ST_ACK) begin
      resp_write <= 1'b1;
      resp_data  <= 32'd0;
    end else if (resp_hs) begin
      resp_write <= 1'b0;
      resp_data  <= 32'd0;
    end
  end

`ifdef SRAM_PKT_DRV_STATS_EN
  // Saturating command counters, bumped as the command enters ISSUE
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_count <= 16'd0;
      rd_count <= 16'd0;
    end else if (cmd_hs) begin
      if (cmd_write && wr_count != 16'hFFFF)  wr_count <= wr_count + 16'd1;
      if (!cmd_write && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_pkt_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sram_pkt_driver
//  Description : Self-checking bench for sram_pkt_driver with a packet-layout
//                reference model and randomized commands.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_pkt_driver;

  localparam int RD_LAT   = 2;
  localparam int IDLE_GAP = 1;
  localparam logic [55:0] IDLE_PKT = {1'b0, 1'b1, 45'd0, 1'b1, 8'd0};

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        cmd_valid, cmd_write, cmd_port, cmd_sram;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_wmask;
  logic [31:0] cmd_wdata;
  logic        cmd_ready;
  logic        resp_valid, resp_ready, resp_write;
  logic [31:0] resp_data;
  logic [55:0] packet_out;
  logic [31:0] sram_data_in;
  logic        busy;
`ifdef SRAM_PKT_DRV_STATS_EN
  logic [15:0] wr_count, rd_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int wr_exp = 0;
  int rd_exp = 0;

  always #5 clk_in = ~clk_in;

  sram_pkt_driver #(.RD_LAT(RD_LAT), .IDLE_GAP(IDLE_GAP)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_port     (cmd_port),
    .cmd_sram     (cmd_sram),
    .cmd_addr     (cmd_addr),
    .cmd_wmask    (cmd_wmask),
    .cmd_wdata    (cmd_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_write   (resp_write),
    .resp_data    (resp_data),
    .packet_out   (packet_out),
    .sram_data_in (sram_data_in),
    .busy         (busy)
`ifdef SRAM_PKT_DRV_STATS_EN
    ,
    .wr_count     (wr_count),
    .rd_count     (rd_count)
`endif
  );

  // Packet built directly from the field layout, MSB first
  function automatic logic [55:0] model_pkt(input logic w, input logic p, input logic s,
                                            input logic [7:0] a, input logic [3:0] m,
                                            input logic [31:0] d);
    if (w)       return {s, 1'b0, 1'b0, m, a, d, 1'b1, 8'd0};
    else if (!p) return {s, 1'b0, 1'b1, 4'd0, a, 32'd0, 1'b1, 8'd0};
    else         return {s, 1'b1, 1'b0, 4'd0, 8'd0, 32'd0, 1'b0, a};
  endfunction

  // One full transaction; entered and left on a falling edge
  task automatic run_cmd(input logic w, input logic p, input logic s, input logic [7:0] a,
                         input logic [3:0] m, input logic [31:0] d, input int stall,
                         input bit keep_valid);
    logic [55:0] exp_pkt;
    logic [31:0] exp_data;
    logic        exp_wr;
    int          t;
    exp_pkt   = model_pkt(w, p, s, a, m, d);
    cmd_write = w; cmd_port = p; cmd_sram = s;
    cmd_addr  = a; cmd_wmask = m; cmd_wdata = d; cmd_valid = 1'b1;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 64) begin
      @(negedge clk_in); t++;
    end
    if (cmd_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL cmd_ready_timeout got %b want 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk_in);
    @(negedge clk_in);
    if (w) wr_exp++; else rd_exp++;
    // Scramble the command bus to prove it is only sampled on handshake
    cmd_valid = keep_valid;
    cmd_write = 1'($urandom); cmd_port = 1'($urandom); cmd_sram = 1'($urandom);
    cmd_addr = 8'($urandom); cmd_wmask = 4'($urandom); cmd_wdata = $urandom;
    n_vec++;
    if (packet_out !== exp_pkt || cmd_ready !== 1'b0 || busy !== 1'b1 || resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL issue_packet got pkt=%h rdy=%b busy=%b rv=%b want pkt=%h rdy=0 busy=1 rv=0",
               packet_out, cmd_ready, busy, resp_valid, exp_pkt);
    end
    if (!w) begin
      sram_data_in = $urandom;
      for (int k = 1; k <= RD_LAT; k++) begin
        @(negedge clk_in);
        n_vec++;
        if (packet_out !== exp_pkt || resp_valid !== 1'b0) begin
          n_err++;
          $display("FAIL wait_hold got pkt=%h rv=%b want pkt=%h rv=0", packet_out, resp_valid, exp_pkt);
        end
        sram_data_in = $urandom;
      end
      exp_data = sram_data_in;
      exp_wr   = 1'b0;
    end else begin
      @(negedge clk_in);
      n_vec++;
      if (packet_out !== IDLE_PKT || resp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL ack_idle got pkt=%h rv=%b want pkt=%h rv=0", packet_out, resp_valid, IDLE_PKT);
      end
      exp_data = 32'd0;
      exp_wr   = 1'b1;
    end
    @(negedge clk_in);
    sram_data_in = $urandom;
    n_vec++;
    if (resp_valid !== 1'b1 || resp_data !== exp_data || resp_write !== exp_wr ||
        packet_out !== IDLE_PKT || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL resp got rv=%b data=%h wr=%b pkt=%h rdy=%b want rv=1 data=%h wr=%b pkt=%h rdy=0",
               resp_valid, resp_data, resp_write, packet_out, cmd_ready, exp_data, exp_wr, IDLE_PKT);
    end
    for (int k = 0; k < stall; k++) begin
      @(negedge clk_in);
      sram_data_in = $urandom;
      n_vec++;
      if (resp_valid !== 1'b1 || resp_data !== exp_data || resp_write !== exp_wr || cmd_ready !== 1'b0) begin
        n_err++;
        $display("FAIL resp_stall got rv=%b data=%h wr=%b rdy=%b want rv=1 data=%h wr=%b rdy=0",
                 resp_valid, resp_data, resp_write, cmd_ready, exp_data, exp_wr);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk_in);
    #1 resp_ready = 1'b0;
    for (int g = 0; g < IDLE_GAP; g++) begin
      @(negedge clk_in);
      n_vec++;
      if (resp_valid !== 1'b0 || cmd_ready !== 1'b0 || packet_out !== IDLE_PKT) begin
        n_err++;
        $display("FAIL gap got rv=%b rdy=%b pkt=%h want rv=0 rdy=0 pkt=%h",
                 resp_valid, cmd_ready, packet_out, IDLE_PKT);
      end
    end
    @(negedge clk_in);
    n_vec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || packet_out !== IDLE_PKT) begin
      n_err++;
      $display("FAIL back_to_idle got rdy=%b busy=%b pkt=%h want rdy=1 busy=0 pkt=%h",
               cmd_ready, busy, packet_out, IDLE_PKT);
    end
  endtask

  task automatic test_reset();
    #3 rst_in = 1'b1;
    #2;
    n_vec++;
    if (packet_out !== IDLE_PKT || cmd_ready !== 1'b0 || resp_valid !== 1'b0 ||
        resp_write !== 1'b0 || resp_data !== 32'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values got pkt=%h rdy=%b rv=%b wr=%b data=%h busy=%b want pkt=%h all else 0",
               packet_out, cmd_ready, resp_valid, resp_write, resp_data, busy, IDLE_PKT);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    n_vec++;
    if (cmd_ready !== 1'b1 || packet_out !== IDLE_PKT) begin
      n_err++;
      $display("FAIL reset_release got rdy=%b pkt=%h want rdy=1 pkt=%h", cmd_ready, packet_out, IDLE_PKT);
    end
    wr_exp = 0; rd_exp = 0;
  endtask

  task automatic test_write();
    run_cmd(1'b1, 1'b0, 1'b1, 8'h3C, 4'hF, 32'hDEADBEEF, 0, 1'b0);
  endtask

  task automatic test_rw_read();
    run_cmd(1'b0, 1'b0, 1'b0, 8'h3C, 4'h0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_ro_read_stall();
    run_cmd(1'b0, 1'b1, 1'b0, 8'hA5, 4'h0, 32'h0, 5, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run_cmd(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 4'($urandom),
              $urandom, int'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_cmd(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 4'($urandom),
              $urandom, 0, 1'b1);
    cmd_valid = 1'b0;
  endtask

`ifdef SRAM_PKT_DRV_STATS_EN
  task automatic test_stats();
    n_vec++;
    if (wr_count !== 16'(wr_exp) || rd_count !== 16'(rd_exp)) begin
      n_err++;
      $display("FAIL stats got wr=%0d rd=%0d want wr=%0d rd=%0d", wr_count, rd_count, wr_exp, rd_exp);
    end
  endtask
`endif

  task automatic test_reset_mid_wait();
    int t;
    cmd_write = 1'b0; cmd_port = 1'b0; cmd_sram = 1'b1;
    cmd_addr = 8'h5A; cmd_wmask = 4'h0; cmd_wdata = 32'h0; cmd_valid = 1'b1;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 64) begin
      @(negedge clk_in); t++;
    end
    @(posedge clk_in);
    @(negedge clk_in);
    cmd_valid = 1'b0;
    @(negedge clk_in);
    n_vec++;
    if (packet_out !== model_pkt(1'b0, 1'b0, 1'b1, 8'h5A, 4'h0, 32'h0)) begin
      n_err++;
      $display("FAIL pre_reset_wait got pkt=%h want %h", packet_out,
               model_pkt(1'b0, 1'b0, 1'b1, 8'h5A, 4'h0, 32'h0));
    end
    rst_in = 1'b1;
    #1;
    n_vec++;
    if (packet_out !== IDLE_PKT || resp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_wait got pkt=%h rv=%b busy=%b rdy=%b want pkt=%h rv=0 busy=0 rdy=0",
               packet_out, resp_valid, busy, cmd_ready, IDLE_PKT);
    end
    wr_exp = 0; rd_exp = 0;
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      n_vec++;
      if (resp_valid !== 1'b0 || cmd_ready !== 1'b1 || packet_out !== IDLE_PKT) begin
        n_err++;
        $display("FAIL after_reset got rv=%b rdy=%b pkt=%h want rv=0 rdy=1 pkt=%h",
                 resp_valid, cmd_ready, packet_out, IDLE_PKT);
      end
    end
  endtask

  initial begin
    rst_in = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_port = 1'b0; cmd_sram = 1'b0;
    cmd_addr = 8'd0; cmd_wmask = 4'd0; cmd_wdata = 32'd0; resp_ready = 1'b0; sram_data_in = 32'd0;
    test_reset();
    test_write();
    test_rw_read();
    test_ro_read_stall();
    test_random();
    test_back_to_back();
`ifdef SRAM_PKT_DRV_STATS_EN
    test_stats();
`endif
    test_reset_mid_wait();
`ifdef SRAM_PKT_DRV_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
